pe_rx_seq_monitor: RTL and testbench
====================================

# pe_rx_seq_monitor

Multi-source receive-sequence monitor for a processing element. It tracks the sequence numbers of normal packets arriving from up to NUM_SRC source PEs and detects gaps and receive timeouts per source. It issues retransmission requests to the PE's packet builder through a valid/ready port, arbitrated round-robin across sources. It generalises single-target receive-miss bookkeeping to a per-channel array with a parameterised packet quota, timeout and request arbitration.

## Interface
- NUM_SRC, 8: number of tracked sources (channel index = source ID)
- ID_W, 4: source ID width
- SEQ_W, 20: sequence-number and miss-count width
- TIME_W, 10: timeout counter width; timeout fires at all-ones
- EXPECT_NOR, 4096: packets expected per source in normal mode
- EXPECT_DBG, 256: packets expected per source in debug mode
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  timer advance enable
- dbg_mode  in  1  selects EXPECT_DBG quota; static during operation
- in_valid  in  1  received packet strobe (one cycle per packet)
- in_retrans  in  1  1 = retransmitted packet, 0 = normal packet
- in_src  in  ID_W  source ID of packet
- in_seq  in  SEQ_W  packet sequence number
- req_valid  out  1  retransmission request pending
- req_ready  in  1  request accepted by packet builder
- req_src  out  ID_W  source to request from
- req_miss  out  SEQ_W  missing-packet count being requested (0 = timeout-only)
- req_timeout  out  1  request caused or accompanied by timeout
- miss_pulse  out  1  one-cycle pulse on any new gap detection
- done_vec  out  NUM_SRC  per-source quota reached
- all_done  out  1  AND of done_vec

## Operation
- Per channel: state {IDLE, ACTIVE, DONE}, last_seq[SEQ_W], miss[SEQ_W], rx_cnt[clog2(EXPECT_NOR+1)], timer[TIME_W], to_flag.
- Packets with in_src >= NUM_SRC are ignored entirely.
- Normal packet, channel IDLE: gap = in_seq (first expected seq is 0). Channel goes to ACTIVE, last_seq = in_seq, rx_cnt +1.
- Normal packet, ACTIVE, in_seq > last_seq: gap = in_seq - last_seq - 1. miss += gap, saturating at all-ones. last_seq = in_seq, rx_cnt +1.
- Normal packet with in_seq <= last_seq (stale or duplicate): no state change except timer clear.
- Retransmitted packet: rx_cnt +1 if not DONE. miss and last_seq unchanged.
- gap > 0 pulses miss_pulse the following cycle.
- Any accepted packet from a channel clears its timer.
- Timer increments when enable and state is ACTIVE. At all-ones it sets to_flag and holds.
- rx_cnt == (dbg_mode ? EXPECT_DBG : EXPECT_NOR) moves the channel to DONE.
- In DONE: packets ignored, timer held 0, channel never becomes eligible.
- Eligible = ACTIVE and (miss != 0 or to_flag).
- Arbiter: when req_valid is low, grant the lowest eligible index at or after rr_ptr (wrapping). Capture req_src/req_miss/req_timeout into output registers.
- Handshake (req_valid & req_ready): the granted channel's miss, to_flag and timer clear; rr_ptr = grant+1 mod NUM_SRC.
- Packet and handshake on the same channel in the same cycle: miss = new gap only. The captured value is what was sent.

## Timing
- All outputs registered. Reset: req_valid 0, req_src 0, req_miss 0, req_timeout 0, miss_pulse 0, done_vec 0, all_done 0. All channels IDLE, counters 0, rr_ptr 0.
- A packet at cycle t is reflected in channel state at t+1.
- req_valid rises no earlier than t+2 after the gap-creating packet.
- req_valid/req_src/req_miss/req_timeout are stable while req_valid & !req_ready. Later eligibility changes, including the channel reaching DONE, do not retract or alter a pending request.
- Back-to-back grants: a new request may assert the cycle after a handshake.
- done_vec/all_done are sticky until reset.

## Structure
- Shared package (pe_pkg): channel state enum, default widths ID_W/SEQ_W/TIME_W, quota constants.
- One sub-module, pe_rx_seq_chan: per-channel state, counters and eligibility, instantiated NUM_SRC times via generate.
- The arbiter and output registers stay in the top.

## Test plan
- Source 2 sends seq 0..9 in order → no miss_pulse, req_valid never asserts, rx_cnt 10.
- Source 1 sends seq 0,1,5 → miss_pulse once; req_valid with req_src 1, req_miss 3; after req_ready, miss 0.
- Source 3 sends seq 0 then idles with enable high for 1023 cycles → req_valid, req_src 3, req_miss 0, req_timeout 1.
- Sources 0, 4, 6 all have gaps and req_ready is held high → grants 0, 4, 6, then wrap. req_ready low for 5 cycles → outputs stable.
- dbg_mode=1, source 5 sends seq 0..255 → done_vec[5] rises after the 256th packet. Further packets are ignored and no timeout request follows.
- Gap packet on source 1 in the same cycle as its request handshake → next request's req_miss equals only the new gap. Asserting rst_n low mid-request clears req_valid asynchronously.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and default widths for the PE receive-sequence monitor.
// The quota constants size the per-channel receive counter.
package pe_pkg;

   localparam int NUM_SRC_DEF    = 8;
   localparam int ID_W_DEF       = 4;
   localparam int SEQ_W_DEF      = 20;
   localparam int TIME_W_DEF     = 10;
   localparam int EXPECT_NOR_DEF = 4096;
   localparam int EXPECT_DBG_DEF = 256;

   typedef enum logic [1:0] {
      CH_IDLE   = 2'd0,
      CH_ACTIVE = 2'd1,
      CH_DONE   = 2'd2
   } chan_state_e;

   // The receive counter must be able to hold the quota value itself.
   function automatic int cnt_width(input int quota);
      return $clog2(quota + 1);
   endfunction

endpackage

// File: rtl/pe_rx_seq_monitor_if.sv
// Packet-in and retransmission-request bus of the receive-sequence monitor.
// slave is the monitor side; master is the packet source / packet builder side.
interface pe_rx_seq_monitor_if
   import pe_pkg::*;
#(
   parameter int ID_W  = ID_W_DEF,
   parameter int SEQ_W = SEQ_W_DEF
);
   logic             in_valid;
   logic             in_retrans;
   logic [ID_W-1:0]  in_src;
   logic [SEQ_W-1:0] in_seq;
   logic             req_valid;
   logic             req_ready;
   logic [ID_W-1:0]  req_src;
   logic [SEQ_W-1:0] req_miss;
   logic             req_timeout;

   modport master (
      output in_valid, in_retrans, in_src, in_seq, req_ready,
      input  req_valid, req_src, req_miss, req_timeout
   );

   modport slave (
      input  in_valid, in_retrans, in_src, in_seq, req_ready,
      output req_valid, req_src, req_miss, req_timeout
   );
endinterface

// File: rtl/pe_rx_seq_chan.sv
// One source channel: sequence tracking, saturating miss count, receive quota,
// receive timeout and request eligibility.
module pe_rx_seq_chan
   import pe_pkg::*;
#(
   parameter int SEQ_W  = SEQ_W_DEF,
   parameter int TIME_W = TIME_W_DEF,
   parameter int CNT_W  = cnt_width(EXPECT_NOR_DEF)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             pkt_valid,
   input  logic             pkt_retrans,
   input  logic [SEQ_W-1:0] pkt_seq,
   input  logic [CNT_W-1:0] quota,
   input  logic             clr,
   output logic             eligible,
   output logic             to_flag,
   output logic             new_gap,
   output logic             done_nxt,
   output logic [SEQ_W-1:0] miss
);

   chan_state_e      state;
   logic [SEQ_W-1:0] last_seq;
   logic [CNT_W-1:0] rx_cnt;
   logic [TIME_W-1:0] timer;
   logic [TIME_W-1:0] timer_nxt;
   logic [SEQ_W-1:0] gap;
   logic [SEQ_W-1:0] miss_base;
   logic [SEQ_W-1:0] miss_nxt;
   logic [SEQ_W:0]   miss_sum;
   logic             accept;
   logic             advance;
   logic             cnt_inc;
   logic             going_done;

   always_comb begin
      // NOTE: every variable gets a default at the top so no path can infer a latch.
      accept     = pkt_valid && (state != CH_DONE);
      advance    = accept && !pkt_retrans && ((state == CH_IDLE) || (pkt_seq > last_seq));
      gap        = (state == CH_IDLE) ? pkt_seq : pkt_seq - last_seq - 1'b1;
      new_gap    = advance && (gap != '0);
      cnt_inc    = accept && (pkt_retrans || advance);
      going_done = cnt_inc && ((rx_cnt + 1'b1) == quota);
      // A handshake drops the count that was sent; a same-cycle gap starts it afresh.
      miss_base  = clr ? '0 : miss;
      miss_sum   = {1'b0, miss_base} + {1'b0, gap};
      miss_nxt   = miss_base;
      if (advance) miss_nxt = miss_sum[SEQ_W] ? '1 : miss_sum[SEQ_W-1:0];
      timer_nxt  = timer;
      if (accept || clr || (state == CH_DONE)) begin
         timer_nxt = '0;
      end else if (enable && (state == CH_ACTIVE) && (timer != '1)) begin
         timer_nxt = timer + 1'b1;
      end
   end

   // NOTE: the channel registers are ordinary flops, not a RAM, so they all take the async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= CH_IDLE;
         last_seq <= '0;
         miss     <= '0;
         rx_cnt   <= '0;
         timer    <= '0;
         to_flag  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (going_done) begin
            state <= CH_DONE;
         end else if (advance && (state == CH_IDLE)) begin
            state <= CH_ACTIVE;
         end
         if (advance) last_seq <= pkt_seq;
         if (cnt_inc) rx_cnt <= rx_cnt + 1'b1;
         miss    <= miss_nxt;
         timer   <= timer_nxt;
         to_flag <= !clr && (to_flag || (timer_nxt == '1));
      end
   end

   assign eligible = (state == CH_ACTIVE) && ((miss != '0) || to_flag);
   assign done_nxt = (state == CH_DONE) || going_done;

endmodule

// File: rtl/pe_rx_seq_monitor.sv
// Multi-source receive-sequence monitor: per-source channels plus a round-robin
// arbiter that issues registered retransmission requests.
module pe_rx_seq_monitor
   import pe_pkg::*;
#(
   parameter int NUM_SRC    = NUM_SRC_DEF,
   parameter int ID_W       = ID_W_DEF,
   parameter int SEQ_W      = SEQ_W_DEF,
   parameter int TIME_W     = TIME_W_DEF,
   parameter int EXPECT_NOR = EXPECT_NOR_DEF,
   parameter int EXPECT_DBG = EXPECT_DBG_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               dbg_mode,
   pe_rx_seq_monitor_if.slave bus,
   output logic               miss_pulse,
   output logic [NUM_SRC-1:0] done_vec,
   output logic               all_done
);

   localparam int CNT_W = cnt_width(EXPECT_NOR);

   logic [CNT_W-1:0]   quota;
   logic [NUM_SRC-1:0] elig;
   logic [NUM_SRC-1:0] to_vec;
   logic [NUM_SRC-1:0] new_gap_vec;
   logic [NUM_SRC-1:0] done_nxt_vec;
   logic [NUM_SRC-1:0] clr_vec;
   logic [SEQ_W-1:0]   miss_arr [NUM_SRC];
   logic [ID_W-1:0]    rr_ptr;
   logic               handshake;
   logic               found;
   logic [NUM_SRC-1:0] gnt_oh;
   logic [ID_W-1:0]    gnt_src;
   logic [SEQ_W-1:0]   gnt_miss;
   logic               gnt_to;

   assign quota     = dbg_mode ? CNT_W'(EXPECT_DBG) : CNT_W'(EXPECT_NOR);
   assign handshake = bus.req_valid && bus.req_ready;

   // Sources at or above NUM_SRC match no channel and are therefore ignored.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_chan
      logic hit;
      assign hit        = bus.in_valid && (bus.in_src == ID_W'(i));
      assign clr_vec[i] = handshake && (bus.req_src == ID_W'(i));

      pe_rx_seq_chan #(
         .SEQ_W  (SEQ_W),
         .TIME_W (TIME_W),
         .CNT_W  (CNT_W)
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst_n),
         .enable      (enable),
         .pkt_valid   (hit),
         .pkt_retrans (bus.in_retrans),
         .pkt_seq     (bus.in_seq),
         .quota       (quota),
         .clr         (clr_vec[i]),
         .eligible    (elig[i]),
         .to_flag     (to_vec[i]),
         .new_gap     (new_gap_vec[i]),
         .done_nxt    (done_nxt_vec[i]),
         .miss        (miss_arr[i])
      );
   end

   // Lowest eligible index at or after rr_ptr, wrapping.
   always_comb begin
      found    = 1'b0;
      gnt_oh   = '0;
      gnt_src  = '0;
      gnt_miss = '0;
      gnt_to   = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && elig[i] && (i == (int'(rr_ptr) + k) % NUM_SRC)) begin
               found     = 1'b1;
               gnt_oh[i] = 1'b1;
            end
         end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         if (gnt_oh[i]) begin
            gnt_src  = ID_W'(i);
            gnt_miss = miss_arr[i];
            gnt_to   = to_vec[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.req_valid   <= 1'b0;
         bus.req_src     <= '0;
         bus.req_miss    <= '0;
         bus.req_timeout <= 1'b0;
         rr_ptr          <= '0;
         miss_pulse      <= 1'b0;
         done_vec        <= '0;
         all_done        <= 1'b0;
      end else begin
         miss_pulse <= |new_gap_vec;
         done_vec   <= done_nxt_vec;
         all_done   <= &done_nxt_vec;
         // A pending request is frozen until accepted, whatever the channel does meanwhile.
         if (handshake) begin
            bus.req_valid <= 1'b0;
            rr_ptr        <= (bus.req_src == ID_W'(NUM_SRC - 1)) ? '0 : bus.req_src + 1'b1;
         end else if (!bus.req_valid && found) begin
            bus.req_valid   <= 1'b1;
            bus.req_src     <= gnt_src;
            bus.req_miss    <= gnt_miss;
            bus.req_timeout <= gnt_to;
         end
      end
   end

endmodule

// File: tb/tb_pe_rx_seq_monitor.sv
// Scenario bench for pe_rx_seq_monitor: expected requests are queued as stimulus
// is driven and compared when the monitor raises req_valid.
module tb_pe_rx_seq_monitor;

   typedef struct packed {
      logic [3:0]  src;
      logic [19:0] miss;
      logic        to;
   } req_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       enable;
   logic       dbg_mode;
   logic       miss_pulse;
   logic [7:0] done_vec;
   logic       all_done;

   int   checks = 0;
   int   errors = 0;
   int   pulse_cnt;
   bit   req_seen;
   req_t exp_q[$];

   pe_rx_seq_monitor_if #(.ID_W(4), .SEQ_W(20)) bus ();

   pe_rx_seq_monitor #(
      .NUM_SRC(8), .ID_W(4), .SEQ_W(20), .TIME_W(10), .EXPECT_NOR(4096), .EXPECT_DBG(256)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .dbg_mode   (dbg_mode),
      .bus        (bus),
      .miss_pulse (miss_pulse),
      .done_vec   (done_vec),
      .all_done   (all_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse_cnt <= 0;
         req_seen  <= 1'b0;
      end else begin
         if (miss_pulse) pulse_cnt <= pulse_cnt + 1;
         if (bus.req_valid) req_seen <= 1'b1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset(input logic dbg);
      bus.in_valid   = 1'b0;
      bus.in_retrans = 1'b0;
      bus.in_src     = '0;
      bus.in_seq     = '0;
      bus.req_ready  = 1'b0;
      enable         = 1'b0;
      dbg_mode       = dbg;
      rst_n          = 1'b0;
      exp_q.delete();
      idle(2);
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic send(input int src, input int seq, input logic retrans);
      bus.in_valid   = 1'b1;
      bus.in_retrans = retrans;
      bus.in_src     = 4'(src);
      bus.in_seq     = 20'(seq);
      idle(1);
      bus.in_valid   = 1'b0;
      bus.in_retrans = 1'b0;
   endtask

   task automatic handshake();
      bus.req_ready = 1'b1;
      idle(1);
      bus.req_ready = 1'b0;
   endtask

   task automatic wait_req(input int budget, output bit ok);
      int n = 0;
      while (n < budget && bus.req_valid !== 1'b1) begin
         idle(1);
         n++;
      end
      ok = (bus.req_valid === 1'b1);
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if (bus.req_valid !== 1'b0 || bus.req_src !== 4'd0 || bus.req_miss !== 20'd0 || bus.req_timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_req: valid=%0b src=%0d miss=%0d to=%0b, expected all 0",
                  bus.req_valid, bus.req_src, bus.req_miss, bus.req_timeout);
      end
      checks++;
      if (miss_pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulse: miss_pulse=%0b, expected 0", miss_pulse);
      end
      checks++;
      if (done_vec !== 8'h00 || all_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_done: done_vec=%h all_done=%0b, expected 00/0", done_vec, all_done);
      end
   endtask

   task automatic test_in_order();
      apply_reset(1'b0);
      for (int s = 0; s < 10; s++) send(2, s, 1'b0);
      send(9, 7, 1'b0);
      send(15, 3, 1'b0);
      idle(10);
      checks++;
      if (pulse_cnt !== 0) begin
         errors++;
         $display("FAIL in_order_pulse: pulses=%0d, expected 0", pulse_cnt);
      end
      checks++;
      if (req_seen !== 1'b0 || done_vec !== 8'h00) begin
         errors++;
         $display("FAIL in_order_req: req_seen=%0b done_vec=%h, expected 0/00", req_seen, done_vec);
      end
   endtask

   task automatic test_gap();
      req_t e;
      bit   ok;
      apply_reset(1'b0);
      send(1, 0, 1'b0);
      send(1, 1, 1'b0);
      send(1, 5, 1'b0);
      exp_q.push_back('{src: 4'd1, miss: 20'd3, to: 1'b0});
      checks++;
      if (miss_pulse !== 1'b1 || bus.req_valid !== 1'b0) begin
         errors++;
         $display("FAIL gap_timing: miss_pulse=%0b req_valid=%0b, expected 1/0", miss_pulse, bus.req_valid);
      end
      wait_req(10, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || bus.req_src !== e.src || bus.req_miss !== e.miss || bus.req_timeout !== e.to) begin
         errors++;
         $display("FAIL gap_req: valid=%0b src=%0d miss=%0d to=%0b, expected src=%0d miss=%0d to=%0b",
                  ok, bus.req_src, bus.req_miss, bus.req_timeout, e.src, e.miss, e.to);
      end
      handshake();
      idle(4);
      checks++;
      if (bus.req_valid !== 1'b0 || pulse_cnt !== 1) begin
         errors++;
         $display("FAIL gap_after_ack: req_valid=%0b pulses=%0d, expected 0/1", bus.req_valid, pulse_cnt);
      end
      send(1, 3, 1'b0);
      send(1, 6, 1'b0);
      send(1, 2, 1'b1);
      idle(4);
      checks++;
      if (bus.req_valid !== 1'b0 || pulse_cnt !== 1) begin
         errors++;
         $display("FAIL gap_stale: req_valid=%0b pulses=%0d, expected 0/1", bus.req_valid, pulse_cnt);
      end
   endtask

   task automatic test_timeout();
      req_t e;
      bit   ok;
      apply_reset(1'b0);
      enable = 1'b1;
      send(3, 0, 1'b0);
      exp_q.push_back('{src: 4'd3, miss: 20'd0, to: 1'b1});
      idle(1000);
      checks++;
      if (bus.req_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: req_valid=%0b after 1000 cycles, expected 0", bus.req_valid);
      end
      wait_req(100, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || bus.req_src !== e.src || bus.req_miss !== e.miss || bus.req_timeout !== e.to) begin
         errors++;
         $display("FAIL timeout_req: valid=%0b src=%0d miss=%0d to=%0b, expected src=%0d miss=%0d to=%0b",
                  ok, bus.req_src, bus.req_miss, bus.req_timeout, e.src, e.miss, e.to);
      end
      handshake();
      enable = 1'b0;
      idle(5);
      checks++;
      if (bus.req_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: req_valid=%0b after ack, expected 0", bus.req_valid);
      end
   endtask

   task automatic test_round_robin();
      req_t e;
      bit   ok;
      bit   stable_bad;
      apply_reset(1'b0);
      send(0, 2, 1'b0);
      send(4, 3, 1'b0);
      send(6, 5, 1'b0);
      exp_q.push_back('{src: 4'd0, miss: 20'd2, to: 1'b0});
      exp_q.push_back('{src: 4'd4, miss: 20'd3, to: 1'b0});
      exp_q.push_back('{src: 4'd6, miss: 20'd5, to: 1'b0});
      for (int g = 0; g < 3; g++) begin
         wait_req(10, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || bus.req_src !== e.src || bus.req_miss !== e.miss || bus.req_timeout !== e.to) begin
            errors++;
            $display("FAIL rr_grant%0d: valid=%0b src=%0d miss=%0d to=%0b, expected src=%0d miss=%0d to=%0b",
                     g, ok, bus.req_src, bus.req_miss, bus.req_timeout, e.src, e.miss, e.to);
         end
         if (g < 2) handshake();
      end
      // Source 6 is pending with req_ready low while new gaps land on 4 and 0.
      stable_bad = 1'b0;
      for (int c = 0; c < 5; c++) begin
         case (c)
            0:       send(4, 10, 1'b0);
            1:       send(0, 7, 1'b0);
            default: idle(1);
         endcase
         if (bus.req_valid !== 1'b1 || bus.req_src !== 4'd6 || bus.req_miss !== 20'd5 || bus.req_timeout !== 1'b0)
            stable_bad = 1'b1;
      end
      checks++;
      if (stable_bad) begin
         errors++;
         $display("FAIL rr_stall: valid=%0b src=%0d miss=%0d, expected 1/6/5 held", bus.req_valid, bus.req_src, bus.req_miss);
      end
      handshake();
      exp_q.push_back('{src: 4'd0, miss: 20'd4, to: 1'b0});
      exp_q.push_back('{src: 4'd4, miss: 20'd6, to: 1'b0});
      for (int g = 3; g < 5; g++) begin
         wait_req(10, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || bus.req_src !== e.src || bus.req_miss !== e.miss || bus.req_timeout !== e.to) begin
            errors++;
            $display("FAIL rr_grant%0d: valid=%0b src=%0d miss=%0d to=%0b, expected src=%0d miss=%0d to=%0b",
                     g, ok, bus.req_src, bus.req_miss, bus.req_timeout, e.src, e.miss, e.to);
         end
         handshake();
      end
   endtask

   task automatic test_quota_done();
      apply_reset(1'b1);
      enable = 1'b1;
      for (int s = 0; s < 256; s++) begin
         send(5, s, 1'b0);
         if (s == 254) begin
            checks++;
            if (done_vec !== 8'h00) begin
               errors++;
               $display("FAIL quota_early: done_vec=%h after 255 packets, expected 00", done_vec);
            end
         end
      end
      checks++;
      if (done_vec !== 8'h20) begin
         errors++;
         $display("FAIL quota_done: done_vec=%h after 256 packets, expected 20", done_vec);
      end
      send(5, 300, 1'b0);
      checks++;
      if (miss_pulse !== 1'b0) begin
         errors++;
         $display("FAIL quota_ignore: miss_pulse=%0b for packet after done, expected 0", miss_pulse);
      end
      idle(1100);
      checks++;
      if (req_seen !== 1'b0 || done_vec !== 8'h20 || all_done !== 1'b0) begin
         errors++;
         $display("FAIL quota_idle: req_seen=%0b done_vec=%h all_done=%0b, expected 0/20/0",
                  req_seen, done_vec, all_done);
      end
      enable = 1'b0;
   endtask

   task automatic test_same_cycle_ack();
      req_t e;
      bit   ok;
      apply_reset(1'b0);
      send(1, 0, 1'b0);
      send(1, 3, 1'b0);
      exp_q.push_back('{src: 4'd1, miss: 20'd2, to: 1'b0});
      for (int g = 0; g < 2; g++) begin
         wait_req(10, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || bus.req_src !== e.src || bus.req_miss !== e.miss || bus.req_timeout !== e.to) begin
            errors++;
            $display("FAIL same_cycle%0d: valid=%0b src=%0d miss=%0d to=%0b, expected src=%0d miss=%0d to=%0b",
                     g, ok, bus.req_src, bus.req_miss, bus.req_timeout, e.src, e.miss, e.to);
         end
         if (g == 0) begin
            // Gap of 4 (3 -> 8) lands in the very cycle the first request is accepted.
            bus.req_ready = 1'b1;
            send(1, 8, 1'b0);
            bus.req_ready = 1'b0;
            exp_q.push_back('{src: 4'd1, miss: 20'd4, to: 1'b0});
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.req_valid !== 1'b0 || bus.req_miss !== 20'd0) begin
         errors++;
         $display("FAIL async_reset: req_valid=%0b req_miss=%0d mid-cycle, expected 0/0", bus.req_valid, bus.req_miss);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_retrans = 1'b0;
      bus.in_src     = '0;
      bus.in_seq     = '0;
      bus.req_ready  = 1'b0;
      enable         = 1'b0;
      dbg_mode       = 1'b0;
      test_reset();
      test_in_order();
      test_gap();
      test_timeout();
      test_round_robin();
      test_quota_done();
      test_same_cycle_ack();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
